// File: rtl/alu_link.sv
// Byte-serial command front end: 9-byte frame {op, A, B} in, one execute cycle,
// 32-bit result out as 4 bytes MSB first over a valid/ready stream.
module alu_link (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [2:0] {S_OP, S_GET_A, S_GET_B, S_EXEC, S_SEND} state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, c_q;
  logic [31:0] res_d;
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        in_acc, out_acc;

  assign in_ready  = (state_q == S_OP) || (state_q == S_GET_A) || (state_q == S_GET_B);
  assign busy      = (state_q != S_OP);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid_q && out_ready;

  // Shifts honour the full 32-bit B: any amount past 31 saturates.
  always_comb begin
    res_d = '0;
    case (op_q)
      3'd0: res_d = a_q + b_q;
      3'd1: res_d = a_q - b_q;
      3'd2: res_d = a_q & b_q;
      3'd3: res_d = a_q | b_q;
      3'd4: res_d = (b_q > 32'd31) ? 32'd0 : (a_q >> b_q[4:0]);
      3'd5: res_d = (b_q > 32'd31) ? {32{a_q[31]}} : 32'($signed(a_q) >>> b_q[4:0]);
      3'd6: res_d = {31'd0, (a_q > b_q)};
      3'd7: res_d = {31'd0, ($signed(a_q) > $signed(b_q))};
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OP;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_OP: if (in_acc) begin
          op_q    <= in_data[2:0];
          cnt_q   <= '0;
          state_q <= S_GET_A;
        end
        S_GET_A: if (in_acc) begin
          a_q   <= {a_q[23:0], in_data};
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= S_GET_B;
        end
        S_GET_B: if (in_acc) begin
          b_q   <= {b_q[23:0], in_data};
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= S_EXEC;
        end
        S_EXEC: begin
          c_q         <= res_d;
          out_data_q  <= res_d[31:24];
          out_valid_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= S_SEND;
        end
        S_SEND: if (out_acc) begin
          // c_q shifts so its top byte is always the one on the wire
          c_q        <= {c_q[23:0], 8'h00};
          out_data_q <= c_q[23:16];
          cnt_q      <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            out_valid_q <= 1'b0;
            state_q     <= S_OP;
          end
        end
        default: state_q <= S_OP;
      endcase
    end
  end

endmodule

// File: doc/alu_link.md
# alu_link

Byte-serial command front end for the team's 32-bit ALU operation set. It receives a 9-byte command frame (opcode, operand A, operand B) over a valid/ready byte stream and computes the result in one internal execute cycle. It then returns the 32-bit result as 4 bytes over a second valid/ready stream. It sits between a byte-wide host link (UART/bench) and the datapath, so ALU operations can be exercised without a parallel bus.

## Interface
Parameters: none.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in_valid  input  1  in_data holds a command byte
- in_data  input  8  command byte
- in_ready  output  1  block accepts a byte this cycle; high in states OP, GET_A, GET_B
- out_valid  output  1  out_data holds a result byte
- out_data  output  8  result byte
- out_ready  input  1  sink accepts the result byte this cycle
- busy  output  1  high whenever state is not OP

## Operation
- Frame in: byte0 = opcode; only in_data[2:0] is used, bits [7:3] are ignored. Bytes 1–4 = A, MSB first. Bytes 5–8 = B, MSB first.
- Frame out: result C, 4 bytes, MSB first.
- Handshakes:
  - An input byte transfers on a rising edge with in_valid && in_ready.
  - An output byte transfers on a rising edge with out_valid && out_ready.
- Opcode set (ALUOp encoding):
  - 0: A+B, mod 2^32
  - 1: A−B, mod 2^32
  - 2: A&B
  - 3: A|B
  - 4: A>>B, logical, using the full 32-bit B; B≥32 gives 0
  - 5: A>>>B, arithmetic, full B; B≥32 gives 32 copies of A[31]
  - 6: unsigned A>B ? 1 : 0
  - 7: signed A>B ? 1 : 0
- States:
  - OP: on accept, latch opcode → GET_A, cnt=0.
  - GET_A: on each accept, A = {A[23:0], in_data}; after the 4th byte (cnt=3) → GET_B, cnt=0.
  - GET_B: same shifting into B; after the 4th byte → EXEC.
  - EXEC: one cycle; register C from the latched op/A/B → SEND, cnt=0. Load out_data = C[31:24] and set out_valid=1 at the same edge.
  - SEND: on each accept, advance to the next lower byte. After the 4th accept, out_valid=0 → OP.
- Without a handshake, state, cnt and out_data hold. out_data must stay stable while out_valid=1 and out_ready=0.
- The datapath is internal. The external ALU module is not instantiated; the op encoding and results must match it bit-for-bit for ops 0–7.

## Timing
- Reset values:
  - state=OP, cnt=0, opcode/A/B/C=0
  - in_ready=1 (first cycle after reset deasserts)
  - out_valid=0, out_data=0x00, busy=0
- Reset mid-frame, in any state: the partial frame is discarded, no output is produced, and the block returns to OP in the next cycle. Reset wins over a simultaneous handshake.
- Latency: 9th input byte accepted at edge t → EXEC during t..t+1 → out_valid=1 with the MSB after edge t+1. Minimum frame-in to first result byte is 1 cycle of EXEC. With out_ready held high, the last result byte is accepted at edge t+5 and in_ready=1 again after that edge.
- in_ready is combinational from state only. It never depends on in_valid.
- in_ready=0 in EXEC and SEND. Input bytes presented then are not consumed; no overlap between frames.
- out_valid is never 1 while in_ready is 1.
- Back-to-back frames: minimum frame period is 9 + 1 + 4 = 14 cycles.

## Test plan
- Reset then op 1 frame {01, 00000003, 00000005} with out_ready=1 → out bytes FF, FF, FF, FE. First out_valid comes 1 cycle after the 9th input accept; in_ready=1 again after the 4th output accept.
- Op 5, A=0x80000000, B=4 → F8 00 00 00. Op 5, B=0x00000020 → FF FF FF FF. Op 4, same A, B=32 → 00 00 00 00.
- Op 6 and op 7 with A=0xFFFFFFFF, B=0x00000001 → op 6 returns 00000001, op 7 returns 00000000. Op 0 with A=0xFFFFFFFF, B=2 → 00000001.
- Backpressure: out_ready low 3 cycles after EXEC → out_valid=1 and out_data=MSB held stable. in_valid pulsed in this window with random data → not consumed, in_ready=0 throughout.
- Gapped input: in_valid toggled randomly across the frame, and byte0=0xFA (bits [7:3] set, op 2) with A=0x0F0F0F0F, B=0x00FF00FF → result 000F000F.
- Reset asserted after 5 input bytes, then a full op 3 frame A=0xF0000000, B=0x0000000F → only F0 00 00 0F emitted. Likewise, reset during SEND after 2 output bytes → out_valid=0 and busy=0 next cycle.
